// File: rtl/bb2v_pkg.sv
`default_nettype none
// ============================================================================
// bb2v_pkg : shared types and constants for the bb2v_multi datapath
// Revision : 1.0
// ============================================================================
package bb2v_pkg;

    typedef logic [63:0] fp64_t;

    localparam fp64_t FP64_ZERO = 64'h0000_0000_0000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_CAND = 2'd2,
        S_OUT  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bb2v_accum.sv
`default_nettype none
// ============================================================================
// bb2v_accum : issue/return tracking and operand-B select around fp64_add
// Revision : 1.0
// ============================================================================
module bb2v_accum
    import bb2v_pkg::*;
#(
    parameter int ADD_LAT = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  i_issue,
    input  logic  i_last,
    input  fp64_t i_a,
    input  fp64_t i_b_term,
    input  fp64_t i_b_cand,
    input  logic  i_sel_cand,
    output logic  o_ret_vld,
    output fp64_t o_ret_sum,
    output logic  o_nxt_vld,
    output logic  o_nxt_last,
    output fp64_t o_nxt_sum
);

    fp64_t w_b;
    assign w_b = i_sel_cand ? i_b_cand : i_b_term;

    fp64_add #(.LAT(ADD_LAT)) u_add (
        .clk       (clk),
        .i_a       (i_a),
        .i_b       (w_b),
        .o_sum     (o_ret_sum),
        .o_sum_nxt (o_nxt_sum)
    );

    // The valid pipe is the job tag: reset empties it so stale sums never return.
    generate
        if (ADD_LAT == 1) begin : g_lat1
            logic r_vld;
            always_ff @(posedge clk) begin
                if (rst) r_vld <= 1'b0;
                else     r_vld <= i_issue;
            end
            assign o_ret_vld  = r_vld;
            assign o_nxt_vld  = i_issue;
            assign o_nxt_last = i_last;
        end else begin : g_latn
            logic [ADD_LAT-1:0] r_vld;
            logic [ADD_LAT-2:0] r_lst;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld <= '0;
                    r_lst <= '0;
                end else begin
                    r_vld[0] <= i_issue;
                    r_lst[0] <= i_last;
                    for (int i = 1; i < ADD_LAT; i++)
                        r_vld[i] <= r_vld[i-1];
                    for (int i = 1; i < ADD_LAT - 1; i++)
                        r_lst[i] <= r_lst[i-1];
                end
            end
            assign o_ret_vld  = r_vld[ADD_LAT-1];
            assign o_nxt_vld  = r_vld[ADD_LAT-2];
            assign o_nxt_last = r_lst[ADD_LAT-2];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/fp64_add.sv
`default_nettype none
// ============================================================================
// fp64_add : binary64 adder, round-to-nearest-even, LAT-deep output pipeline
// Revision : 1.0
// ============================================================================
module fp64_add #(
    parameter int LAT = 4
) (
    input  logic        clk,
    input  logic [63:0] i_a,
    input  logic [63:0] i_b,
    output logic [63:0] o_sum,
    output logic [63:0] o_sum_nxt
);

    function automatic logic [5:0] lzc56(input logic [55:0] v);
        lzc56 = 6'd56;
        for (int i = 0; i < 56; i++)
            if (v[i]) lzc56 = 6'(55 - i);
    endfunction

    logic [63:0]  w_big, w_sml, w_res;
    logic [11:0]  w_eb, w_es, w_d, w_shl, w_e;
    logic [55:0]  w_mb, w_ms, w_n;
    logic [127:0] w_shv;
    logic [56:0]  w_s;
    logic [53:0]  w_m;
    logic [5:0]   w_lz;
    logic         w_sub, w_inc, w_a_spc, w_b_spc;

    always_comb begin
        w_big = (i_a[62:0] >= i_b[62:0]) ? i_a : i_b;
        w_sml = (i_a[62:0] >= i_b[62:0]) ? i_b : i_a;
        w_sub = w_big[63] ^ w_sml[63];
        w_eb  = (w_big[62:52] == 11'd0) ? 12'd1 : {1'b0, w_big[62:52]};
        w_es  = (w_sml[62:52] == 11'd0) ? 12'd1 : {1'b0, w_sml[62:52]};
        w_mb  = {(w_big[62:52] != 11'd0), w_big[51:0], 3'b000};
        w_ms  = {(w_sml[62:52] != 11'd0), w_sml[51:0], 3'b000};
        w_d   = w_eb - w_es;
        // Alignment keeps guard/round bits; everything shifted lower folds into sticky.
        w_shv = {w_ms, 72'd0} >> ((w_d > 12'd63) ? 6'd63 : w_d[5:0]);
        if (w_sub)
            w_s = {1'b0, w_mb} - {1'b0, w_shv[127:73], w_shv[72] | (|w_shv[71:0])};
        else
            w_s = {1'b0, w_mb} + {1'b0, w_shv[127:73], w_shv[72] | (|w_shv[71:0])};
        w_lz  = lzc56(w_s[55:0]);
        w_shl = ({6'd0, w_lz} < (w_eb - 12'd1)) ? {6'd0, w_lz} : (w_eb - 12'd1);
        if (w_s[56]) begin
            w_n = {w_s[56:2], w_s[1] | w_s[0]};
            w_e = w_eb + 12'd1;
        end else begin
            w_n = w_s[55:0] << w_shl;
            w_e = w_eb - w_shl;
        end
        w_inc = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
        w_m   = {1'b0, w_n[55:3]} + {53'd0, w_inc};
        if (w_m[53]) begin
            w_m = w_m >> 1;
            w_e = w_e + 12'd1;
        end
        w_a_spc = &i_a[62:52];
        w_b_spc = &i_b[62:52];
        if (w_a_spc && w_b_spc && (i_a[63] ^ i_b[63]))
            w_res = 64'h7FF8_0000_0000_0000;
        else if (w_a_spc)
            w_res = i_a;
        else if (w_b_spc)
            w_res = i_b;
        else if (w_s == 57'd0)
            w_res = {w_big[63] & w_sml[63], 63'd0};
        else if (w_e >= 12'd2047)
            w_res = {w_big[63], 11'h7FF, 52'd0};
        else
            w_res = {w_big[63], (w_m[52] ? w_e[10:0] : 11'd0), w_m[51:0]};
    end

    logic [63:0] r_pipe [LAT];

    always_ff @(posedge clk) begin
        r_pipe[0] <= w_res;
        for (int i = 1; i < LAT; i++)
            r_pipe[i] <= r_pipe[i-1];
    end

    assign o_sum = r_pipe[LAT-1];

    generate
        if (LAT == 1) begin : g_lat1
            assign o_sum_nxt = w_res;
        end else begin : g_latn
            assign o_sum_nxt = r_pipe[LAT-2];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/bb2v_multi.sv
`default_nettype none
// ============================================================================
// bb2v_multi : vinput = backbone + sum of alpha_u terms over non-excluded layers
//              Optional macro BB2V_ALL_CAND_EN emits all A candidates.
// Revision : 1.0
// ============================================================================
module bb2v_multi
    import bb2v_pkg::*;
#(
    parameter  int J       = 14,
    parameter  int A       = 2,
    parameter  int ADD_LAT = 4,
    localparam int J_WIDTH = $clog2(J) + 1,
    localparam int A_WIDTH = $clog2(A) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [63:0]            backbone,
    input  logic                   backbone_tvalid,
    input  logic [J*A_WIDTH-1:0]   x_initial,
    input  logic                   x_initial_tvalid,
    input  logic [J_WIDTH-1:0]     ind_j,
    input  logic                   ind_j_tvalid,
    input  logic [J*A*64-1:0]      alpha_u,
    input  logic                   alpha_u_tvalid,
    output logic                   in_ready,
    output logic [63:0]            vinput,
    output logic [A_WIDTH-1:0]     vinput_idx,
    output logic                   vinput_last,
    output logic                   vinput_tvalid,
    input  logic                   vinput_tready,
    output logic [1:0]             err
);

    localparam logic [J_WIDTH-1:0] c_J = J_WIDTH'(J);
    localparam logic [A_WIDTH-1:0] c_A = A_WIDTH'(A);

    state_t                 r_state;
    fp64_t                  r_backbone, r_vinput;
    logic [J*A_WIDTH-1:0]   r_x;
    logic [J_WIDTH-1:0]     r_ind, r_j, r_left;
    logic [J*A*64-1:0]      r_alpha;
    logic [3:0]             r_got;
    logic                   r_first, r_last, r_tvalid, r_ready;
    logic [A_WIDTH-1:0]     r_idx;
    logic [1:0]             r_err;

    logic [3:0]             w_strb, w_got;
    logic [J_WIDTH-1:0]     w_ind_nxt, w_nj;
    logic [A_WIDTH-1:0]     w_sym;
    logic                   w_sym_bad, w_no_excl, w_in_cand, w_issue, w_last;
    logic                   w_ret_vld, w_nxt_vld, w_nxt_last;
    fp64_t                  w_term, w_b_cand, w_base, w_op_a, w_ret_sum, w_nxt_sum;

    assign w_strb    = {alpha_u_tvalid, ind_j_tvalid, x_initial_tvalid, backbone_tvalid};
    assign w_got     = r_got | w_strb;
    assign w_ind_nxt = ind_j_tvalid ? ind_j : r_ind;
    assign w_no_excl = (r_ind >= c_J);
    assign w_sym     = r_x[r_j*A_WIDTH +: A_WIDTH];
    assign w_sym_bad = (w_sym >= c_A);
    assign w_term    = w_sym_bad ? FP64_ZERO : r_alpha[(r_j*A + w_sym)*64 +: 64];
    // Next layer after r_j, stepping over the excluded one.
    assign w_nj      = ((r_j + J_WIDTH'(1)) == r_ind) ? (r_j + J_WIDTH'(2)) : (r_j + J_WIDTH'(1));

`ifdef BB2V_ALL_CAND_EN
    fp64_t              r_base;
    logic [A_WIDTH-1:0] r_a;
    assign w_in_cand = (r_state == S_CAND);
    assign w_base    = r_base;
    assign w_b_cand  = w_no_excl ? FP64_ZERO : r_alpha[(r_ind*A + r_a)*64 +: 64];
`else
    assign w_in_cand = 1'b0;
    assign w_base    = FP64_ZERO;
    assign w_b_cand  = FP64_ZERO;
`endif

    assign w_issue = ((r_state == S_ACC) && (r_first || w_ret_vld)) || (w_in_cand && r_first);
    assign w_op_a  = w_in_cand ? w_base : (r_first ? r_backbone : w_ret_sum);
    assign w_last  = w_in_cand || (r_left == J_WIDTH'(1));

    bb2v_accum #(.ADD_LAT(ADD_LAT)) u_accum (
        .clk        (clk),
        .rst        (rst),
        .i_issue    (w_issue),
        .i_last     (w_last),
        .i_a        (w_op_a),
        .i_b_term   (w_term),
        .i_b_cand   (w_b_cand),
        .i_sel_cand (w_in_cand),
        .o_ret_vld  (w_ret_vld),
        .o_ret_sum  (w_ret_sum),
        .o_nxt_vld  (w_nxt_vld),
        .o_nxt_last (w_nxt_last),
        .o_nxt_sum  (w_nxt_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_got      <= 4'd0;
            r_backbone <= FP64_ZERO;
            r_x        <= '0;
            r_ind      <= '0;
            r_alpha    <= '0;
            r_j        <= '0;
            r_left     <= '0;
            r_first    <= 1'b0;
            r_ready    <= 1'b1;
            r_vinput   <= FP64_ZERO;
            r_idx      <= '0;
            r_last     <= 1'b0;
            r_tvalid   <= 1'b0;
            r_err      <= 2'b00;
`ifdef BB2V_ALL_CAND_EN
            r_base     <= FP64_ZERO;
            r_a        <= '0;
`endif
        end else begin
            if ((|w_strb) && !r_ready)
                r_err[0] <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (backbone_tvalid)  r_backbone <= backbone;
                    if (x_initial_tvalid) r_x        <= x_initial;
                    if (ind_j_tvalid)     r_ind      <= ind_j;
                    if (alpha_u_tvalid)   r_alpha    <= alpha_u;
                    if (&w_got) begin
                        r_got   <= 4'd0;
                        r_state <= S_ACC;
                        r_ready <= 1'b0;
                        r_first <= 1'b1;
                        r_j     <= (w_ind_nxt == '0) ? J_WIDTH'(1) : '0;
                        r_left  <= (w_ind_nxt >= c_J) ? c_J : (c_J - J_WIDTH'(1));
                        if (w_ind_nxt >= c_J) r_err[1] <= 1'b1;
`ifdef BB2V_ALL_CAND_EN
                        r_a     <= '0;
`endif
                    end else begin
                        r_got <= w_got;
                    end
                end
                S_ACC: begin
                    if (w_issue) begin
                        r_first <= 1'b0;
                        r_j     <= w_nj;
                        r_left  <= r_left - J_WIDTH'(1);
                        if (w_sym_bad) r_err[1] <= 1'b1;
                    end
                    if (w_nxt_vld && w_nxt_last) begin
`ifdef BB2V_ALL_CAND_EN
                        r_base   <= w_nxt_sum;
                        r_first  <= 1'b1;
                        r_state  <= S_CAND;
`else
                        r_vinput <= w_nxt_sum;
                        r_idx    <= '0;
                        r_last   <= 1'b1;
                        r_tvalid <= 1'b1;
                        r_state  <= S_OUT;
`endif
                    end
                end
`ifdef BB2V_ALL_CAND_EN
                S_CAND: begin
                    if (w_issue) r_first <= 1'b0;
                    if (w_nxt_vld && w_nxt_last) begin
                        r_vinput <= w_nxt_sum;
                        r_idx    <= r_a;
                        r_last   <= (r_a == A_WIDTH'(A - 1));
                        r_tvalid <= 1'b1;
                        r_state  <= S_OUT;
                    end
                end
`endif
                S_OUT: begin
                    if (vinput_tready) begin
                        r_tvalid <= 1'b0;
                        if (r_last) begin
                            r_state <= S_IDLE;
                            r_ready <= 1'b1;
                        end
`ifdef BB2V_ALL_CAND_EN
                        else begin
                            r_a     <= r_a + A_WIDTH'(1);
                            r_first <= 1'b1;
                            r_state <= S_CAND;
                        end
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready      = r_ready;
    assign vinput        = r_vinput;
    assign vinput_idx    = r_idx;
    assign vinput_last   = r_last;
    assign vinput_tvalid = r_tvalid;
    assign err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bb2v_multi.sv
`default_nettype none
// ============================================================================
// tb_bb2v_multi : directed scoreboard bench for bb2v_multi (honours BB2V_ALL_CAND_EN)
// Revision : 1.0
// ============================================================================
module tb_bb2v_multi;

    localparam int J = 14, A = 2, ADD_LAT = 4, JW = 5, AW = 2;
    localparam logic [63:0] F1  = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] F2  = 64'h4000_0000_0000_0000;
    localparam logic [63:0] F5  = 64'h4014_0000_0000_0000;
    localparam logic [63:0] F20 = 64'h4034_0000_0000_0000;
    localparam logic [63:0] F21 = 64'h4035_0000_0000_0000;
    localparam logic [63:0] F22 = 64'h4036_0000_0000_0000;
`ifdef BB2V_ALL_CAND_EN
    localparam int CAND_LAT = ADD_LAT;
`else
    localparam int CAND_LAT = 0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [63:0]       backbone = '0;
    logic              backbone_tvalid = 1'b0;
    logic [J*AW-1:0]   x_initial = '0;
    logic              x_initial_tvalid = 1'b0;
    logic [JW-1:0]     ind_j = '0;
    logic              ind_j_tvalid = 1'b0;
    logic [J*A*64-1:0] alpha_u = '0;
    logic              alpha_u_tvalid = 1'b0;
    logic              in_ready;
    logic [63:0]       vinput;
    logic [AW-1:0]     vinput_idx;
    logic              vinput_last;
    logic              vinput_tvalid;
    logic              vinput_tready = 1'b1;
    logic [1:0]        err;

    always #5 clk = ~clk;

    bb2v_multi dut (
        .clk              (clk),
        .rst              (rst),
        .backbone         (backbone),
        .backbone_tvalid  (backbone_tvalid),
        .x_initial        (x_initial),
        .x_initial_tvalid (x_initial_tvalid),
        .ind_j            (ind_j),
        .ind_j_tvalid     (ind_j_tvalid),
        .alpha_u          (alpha_u),
        .alpha_u_tvalid   (alpha_u_tvalid),
        .in_ready         (in_ready),
        .vinput           (vinput),
        .vinput_idx       (vinput_idx),
        .vinput_last      (vinput_last),
        .vinput_tvalid    (vinput_tvalid),
        .vinput_tready    (vinput_tready),
        .err              (err)
    );

    typedef struct packed {
        logic [63:0]   v;
        logic [AW-1:0] idx;
        logic          last;
    } beat_t;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (vinput_tvalid !== 1'b1 && n < 300) begin
            step();
            n++;
        end
    endtask

    task automatic push_job(input logic [63:0] base, input logic [63:0] c0, input logic [63:0] c1);
`ifdef BB2V_ALL_CAND_EN
        sb.push_back('{c0, 2'd0, 1'b0});
        sb.push_back('{c1, 2'd1, 1'b1});
`else
        sb.push_back('{base, 2'd0, 1'b1});
`endif
    endtask

    // Returns right after the edge that samples the final strobe.
    task automatic start_job(input logic [63:0] bb, input logic [JW-1:0] ind, input bit spread);
        backbone = bb;
        ind_j    = ind;
        if (!spread) begin
            {backbone_tvalid, x_initial_tvalid, ind_j_tvalid, alpha_u_tvalid} = 4'hF;
            step();
            {backbone_tvalid, x_initial_tvalid, ind_j_tvalid, alpha_u_tvalid} = 4'h0;
        end else begin
            x_initial_tvalid = 1'b1; step(); x_initial_tvalid = 1'b0;
            repeat (2) step();
            alpha_u_tvalid = 1'b1;   step(); alpha_u_tvalid = 1'b0;
            step();
            backbone_tvalid = 1'b1;  step(); backbone_tvalid = 1'b0;
            repeat (3) step();
            ind_j_tvalid = 1'b1;     step(); ind_j_tvalid = 1'b0;
        end
    endtask

    task automatic run_beats(input int first_lat, input int stall);
        int    n;
        beat_t e;
        bit    first;
        first = 1'b1;
        while (sb.size() > 0) begin
            vinput_tready = (first && stall > 0) ? 1'b0 : 1'b1;
            wait_valid(n);
            if (first && first_lat >= 0) chk("first_latency", 128'(n), 128'(first_lat));
            else if (!first)             chk("beat_gap", 128'(n), 128'(ADD_LAT));
            e = sb.pop_front();
            chk("beat", {vinput_tvalid, vinput, vinput_idx, vinput_last}, {1'b1, e});
            if (first && stall > 0) begin
                for (int k = 0; k < stall; k++) begin
                    step();
                    chk("stall_hold", {vinput_tvalid, vinput, vinput_idx, vinput_last}, {1'b1, e});
                end
                vinput_tready = 1'b1;
            end
            step();
            first = 1'b0;
        end
        chk("ready_after_job", {126'd0, vinput_tvalid, in_ready}, 128'b01);
    endtask

    initial begin
        for (int j = 0; j < J; j++) begin
            alpha_u[(j*A + 0)*64 +: 64] = F1;
            alpha_u[(j*A + 1)*64 +: 64] = F2;
            x_initial[j*AW +: AW]       = AW'(j & 1);
        end

        repeat (3) step();
        rst = 1'b0;
        step();
        chk("reset_state", {vinput, vinput_idx, vinput_last, vinput_tvalid, in_ready, err},
            {64'd0, 2'd0, 1'b0, 1'b0, 1'b1, 2'b00});

        // Vector V, all strobes together
        push_job(F20, F21, F22);
        start_job(F1, 5'd7, 1'b0);
        chk("in_ready_busy", 128'(in_ready), 128'd0);
        run_beats((J-1)*ADD_LAT + CAND_LAT, 0);

        // Strobes spread over cycles 0/3/5/9
        push_job(F20, F21, F22);
        start_job(F1, 5'd7, 1'b1);
        run_beats((J-1)*ADD_LAT + CAND_LAT, 0);

        // Backpressure on the first beat
        push_job(F20, F21, F22);
        start_job(F1, 5'd7, 1'b0);
        run_beats((J-1)*ADD_LAT + CAND_LAT, 10);
        chk("err_clean", 128'(err), 128'b00);

        // Strobe during ACC is dropped
        push_job(F20, F21, F22);
        start_job(F1, 5'd7, 1'b0);
        repeat (10) step();
        backbone = F5; backbone_tvalid = 1'b1;
        step();
        backbone_tvalid = 1'b0;
        chk("err_drop", 128'(err), 128'b01);
        run_beats(-1, 0);

        // Reset mid-job aborts and discards in-flight sums
        start_job(F1, 5'd7, 1'b0);
        repeat (8) step();
        rst = 1'b1; step(); rst = 1'b0;
        chk("reset_midjob", {vinput, vinput_idx, vinput_last, vinput_tvalid, in_ready, err},
            {64'd0, 2'd0, 1'b0, 1'b0, 1'b1, 2'b00});
        repeat (ADD_LAT + 3) step();
        chk("no_stale_beat", 128'(vinput_tvalid), 128'd0);

        // No layer excluded
        push_job(F22, F22, F22);
        start_job(F1, 5'd15, 1'b0);
        run_beats(J*ADD_LAT + CAND_LAT, 0);
        chk("err_range", 128'(err), 128'b10);

        // Clean job after reset
        rst = 1'b1; step(); rst = 1'b0; step();
        push_job(F20, F21, F22);
        start_job(F1, 5'd7, 1'b0);
        run_beats((J-1)*ADD_LAT + CAND_LAT, 0);
        chk("err_final", 128'(err), 128'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
